// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand forwarding select and decode stall scoreboard
module hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 2)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [SEL_W-1:0]          issue_rdy,
  input  logic                      issue_md,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  input  logic                      md_done,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  bypass_sel,
  output logic                      md_busy,
  output logic [REG_AW-1:0]         md_rd
);

  // Index k holds the instruction in post-decode stage k+1 (0 = X).
  logic              e_v_q   [FWD_DEPTH];
  logic              e_v_d   [FWD_DEPTH];
  logic [REG_AW-1:0] e_rd_q  [FWD_DEPTH];
  logic [REG_AW-1:0] e_rd_d  [FWD_DEPTH];
  logic [SEL_W-1:0]  e_rdy_q [FWD_DEPTH];
  logic [SEL_W-1:0]  e_rdy_d [FWD_DEPTH];

  logic              md_busy_q, md_busy_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;

  logic [NUM_SRC-1:0] src_stall;
  logic               md_block;
  logic               accept;

  assign md_busy = md_busy_q;
  assign md_rd   = md_rd_q;

  // Per operand: youngest pipe producer wins; too-young producer or pending mult/div stalls.
  always_comb begin
    logic [REG_AW-1:0] sreg;
    logic              hit;
    logic [SEL_W-1:0]  hit_stage;
    logic [SEL_W-1:0]  hit_rdy;
    bypass_sel = '0;
    src_stall  = '0;
    sreg       = '0;
    hit        = 1'b0;
    hit_stage  = '0;
    hit_rdy    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sreg      = src_reg[i*REG_AW +: REG_AW];
      hit       = 1'b0;
      hit_stage = '0;
      hit_rdy   = '0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (e_v_q[k] && (e_rd_q[k] == sreg)) begin
          hit       = 1'b1;
          hit_stage = SEL_W'(k + 1);
          hit_rdy   = e_rdy_q[k];
        end
      end
      if (src_valid[i] && (sreg != '0)) begin
        if (hit) begin
          if (hit_stage >= hit_rdy) begin
            bypass_sel[i*SEL_W +: SEL_W] = hit_stage;
          end else begin
            src_stall[i] = 1'b1;
          end
        end else if (md_busy_q && (md_rd_q == sreg)) begin
          if (md_done) begin
            bypass_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_DEPTH + 1);
          end else begin
            src_stall[i] = 1'b1;
          end
        end
      end
    end
  end

  // Structural mult/div hazards: unit occupied, or write-after-write on its destination.
  always_comb begin
    md_block = 1'b0;
    if (issue_valid && md_busy_q && !md_done) begin
      if (issue_md || (issue_we && (issue_rd == md_rd_q))) begin
        md_block = 1'b1;
      end
    end
    stall  = (|src_stall) | md_block;
    accept = issue_valid & ~stall & ~flush;
  end

  // Next-state: shift the pipe every cycle, load X from decode, track the mult/div result.
  always_comb begin
    e_v_d[0]   = accept & issue_we & ~issue_md & (issue_rd != '0);
    e_rd_d[0]  = issue_rd;
    e_rdy_d[0] = issue_rdy;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      // A flushed X entry never reaches M.
      e_v_d[k]   = (k == 1) ? (e_v_q[0] & ~flush) : e_v_q[k-1];
      e_rd_d[k]  = e_rd_q[k-1];
      e_rdy_d[k] = e_rdy_q[k-1];
    end
    md_busy_d = md_busy_q;
    md_rd_d   = md_rd_q;
    if (accept && issue_md && issue_we && (issue_rd != '0)) begin
      md_busy_d = 1'b1;
      md_rd_d   = issue_rd;
    end else if (md_done) begin
      md_busy_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        e_v_q[k]   <= 1'b0;
        e_rd_q[k]  <= '0;
        e_rdy_q[k] <= '0;
      end
      md_busy_q <= 1'b0;
      md_rd_q   <= '0;
    end else begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        e_v_q[k]   <= e_v_d[k];
        e_rd_q[k]  <= e_rd_d[k];
        e_rdy_q[k] <= e_rdy_d[k];
      end
      md_busy_q <= md_busy_d;
      md_rd_q   <= md_rd_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int REG_AW    = 5;
  localparam int NUM_SRC   = 2;
  localparam int FWD_DEPTH = 3;
  localparam int SEL_W     = 3;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      issue_valid, issue_we, issue_md, flush, md_done;
  logic [REG_AW-1:0]         issue_rd;
  logic [SEL_W-1:0]          issue_rdy;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*REG_AW-1:0] src_reg;
  logic                      stall, md_busy;
  logic [NUM_SRC*SEL_W-1:0]  bypass_sel;
  logic [REG_AW-1:0]         md_rd;

  hazard_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_rdy(issue_rdy), .issue_md(issue_md), .flush(flush),
    .src_valid(src_valid), .src_reg(src_reg), .md_done(md_done), .stall(stall),
    .bypass_sel(bypass_sel), .md_busy(md_busy), .md_rd(md_rd)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a history of issued register writers, each aged by clock count since issue.
  typedef struct { int cyc; int rd; int rdy; bit killed; } rec_t;
  rec_t recs[$];
  int   now = 0;
  bit   m_busy = 0;
  int   m_rd = 0;
  bit   exp_stall = 0;
  int   exp_sel [NUM_SRC];

  function automatic void eval();
    int r, best, brdy, st;
    exp_stall = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_sel[i] = 0;
      r = int'(src_reg[i*REG_AW +: REG_AW]);
      if (src_valid[i] && r != 0) begin
        best = 0;
        brdy = 0;
        foreach (recs[j]) begin
          st = now - recs[j].cyc;
          if (!recs[j].killed && recs[j].rd == r && st >= 1 && st <= FWD_DEPTH && (best == 0 || st < best)) begin
            best = st;
            brdy = recs[j].rdy;
          end
        end
        if (best != 0) begin
          if (best >= brdy) exp_sel[i] = best;
          else exp_stall = 1;
        end else if (m_busy && m_rd == r) begin
          if (md_done) exp_sel[i] = FWD_DEPTH + 1;
          else exp_stall = 1;
        end
      end
    end
    if (issue_valid && m_busy && !md_done && (issue_md || (issue_we && int'(issue_rd) == m_rd)))
      exp_stall = 1;
  endfunction

  // Compare process: every cycle, mid low phase.
  always @(negedge clock) begin
    eval();
    chk("stall", int'(stall), int'(exp_stall));
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("bypass_sel[%0d]", i), int'(bypass_sel[i*SEL_W +: SEL_W]), exp_sel[i]);
    chk("md_busy", int'(md_busy), int'(m_busy));
    chk("md_rd", int'(md_rd), m_rd);
  end

  // Model advance at each clock edge.
  always @(posedge clock or negedge reset) begin
    bit acc;
    if (!reset) begin
      recs.delete();
      m_busy = 0;
      m_rd = 0;
      now = 0;
    end else begin
      acc = issue_valid && !exp_stall && !flush;
      if (flush) begin
        foreach (recs[j]) if (now - recs[j].cyc == 1) recs[j].killed = 1;
      end
      if (acc && issue_we && !issue_md && issue_rd != 0) begin
        assert (int'(issue_rdy) <= FWD_DEPTH) else $error("issue_rdy above FWD_DEPTH");
        recs.push_back('{now, int'(issue_rd), int'(issue_rdy), 1'b0});
      end
      if (acc && issue_md && issue_we && issue_rd != 0) begin
        m_busy = 1;
        m_rd = int'(issue_rd);
      end else if (md_done) begin
        m_busy = 0;
      end
      now++;
      while (recs.size() > 0 && now - recs[0].cyc > FWD_DEPTH) void'(recs.pop_front());
    end
  end

  task automatic set_in(bit iv, bit we, int rd, int rdy, bit md, bit fl,
                        bit [1:0] sv, int s0, int s1, bit done);
    issue_valid = iv;
    issue_we    = we;
    issue_rd    = REG_AW'(rd);
    issue_rdy   = SEL_W'(rdy);
    issue_md    = md;
    flush       = fl;
    src_valid   = sv;
    src_reg     = {REG_AW'(s1), REG_AW'(s0)};
    md_done     = done;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(string nm, int st, int s0, int s1);
    @(negedge clock);
    #1;
    chk({nm, " stall"}, int'(stall), st);
    chk({nm, " sel0"}, int'(bypass_sel[0 +: SEL_W]), s0);
    chk({nm, " sel1"}, int'(bypass_sel[SEL_W +: SEL_W]), s1);
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 2'b11, 3, 4, 0);
    tick();
    tick();
    reset = 1'b1;

    lit("reset", 0, 0, 0);
    chk("reset md_busy", int'(md_busy), 0);
    tick();

    // ALU result walks X, M, W then leaves.
    set_in(1, 1, 5, 1, 0, 0, 2'b11, 3, 4, 0);
    lit("add_issue", 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 0);
    lit("fwd_x", 0, 1, 0);
    tick();
    lit("fwd_m", 0, 2, 0);
    tick();
    lit("fwd_w", 0, 3, 0);
    tick();
    lit("fwd_gone", 0, 0, 0);
    tick();

    // Load-use: one bubble, then forward from M.
    set_in(1, 1, 6, 2, 0, 0, 2'b00, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 0);
    lit("load_use", 1, 0, 0);
    tick();
    lit("load_fwd", 0, 2, 0);
    tick();

    // Mult/div: dependent read, second mul and WAW all stall until done.
    set_in(1, 1, 7, 1, 1, 0, 2'b00, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0);
    @(negedge clock);
    #1;
    chk("mul md_busy", int'(md_busy), 1);
    chk("mul md_rd", int'(md_rd), 7);
    lit("md_wait", 1, 0, 0);
    tick();
    set_in(1, 1, 10, 1, 1, 0, 2'b00, 0, 0, 0);
    lit("md_second", 1, 0, 0);
    tick();
    set_in(1, 1, 7, 1, 0, 0, 2'b00, 0, 0, 0);
    lit("md_waw", 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 1);
    lit("md_done_fwd", 0, FWD_DEPTH + 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("md_cleared", int'(md_busy), 0);
    tick();

    // Youngest producer wins; r0 never forwards.
    set_in(1, 1, 8, 1, 0, 0, 2'b00, 0, 0, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b11, 8, 0, 0);
    lit("youngest", 0, 1, 0);
    tick();

    // Flush kills the X entry.
    set_in(1, 1, 9, 1, 0, 0, 2'b00, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 2'b01, 9, 0, 0);
    lit("flush_cycle", 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0);
    lit("flushed_m", 0, 0, 0);
    tick();
    lit("flushed_w", 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a multiply.
    set_in(1, 1, 11, 1, 1, 0, 2'b00, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 11, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async md_busy", int'(md_busy), 0);
    chk("async stall", int'(stall), 0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 7),
             $urandom_range(1, 2), $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
             m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
